// File: rtl/burst_mem_slave_pkg.sv
// burst_mem_slave shared types: FSM state encoding
// and the burst-length counter width.
package burst_mem_slave_pkg;

  localparam int BURST_W = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    READ    = 3'd2,
    WRITE   = 3'd3,
    RD_END  = 3'd4
  } state_t;

endpackage

// File: rtl/burst_mem_slave_ram.sv
// sp_ram_be: single-port RAM, synchronous read, byte-lane write.
// Ports: clock, write_enable, byte_enables, address, write_data, read_data.
module sp_ram_be #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clock,
  input  logic                 write_enable,
  input  logic [3:0]           byte_enables,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (write_enable)
      for (int i = 0; i < 4; i++)
        if (byte_enables[i])
          mem[address][8*i +: 8] <= write_data[8*i +: 8];
    read_data <= mem[address];
  end

endmodule

// File: rtl/burst_mem_slave.sv
// Burst bus slave memory for the DMA: burst read/write, busy, error.
// Ports: clock/reset, begin/address_data/burst_size/read_n_write/
// byte_enables/data_valid/end inputs; read data, valid, end, busy, error out.
module burst_mem_slave
  import burst_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_BITS  = 9,
  parameter int          BUSY_EVERY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic [31:0] address_data_in,
  input  logic [7:0]  burst_size_in,
  input  logic        read_n_write_in,
  input  logic [3:0]  byte_enables_in,
  input  logic        data_valid_in,
  input  logic        end_transaction_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam logic [ADDR_BITS-1:0] TOP = '1;
  localparam int CNT_W =
    (BUSY_EVERY > 1) ? $clog2(BUSY_EVERY) : 1;

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] index, index_n;
  logic [BURST_W-1:0]   remaining, remaining_n;
  logic [CNT_W-1:0]     count, count_n;
  logic                 busy, busy_n;
  logic                 error, error_n;
  logic                 select, accept, last, at_top;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [31:0]          ram_rdata;

  assign select =
    address_data_in[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS];
  assign accept =
    (state == WRITE) && data_valid_in && !busy;
  assign last   = remaining == BURST_W'(1);
  assign at_top = index == TOP;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      remaining <= '0;
      count     <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      index     <= index_n;
      remaining <= remaining_n;
      count     <= count_n;
      busy      <= busy_n;
      error     <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    index_n     = index;
    remaining_n = remaining;
    count_n     = count;
    busy_n      = 1'b0;
    error_n     = 1'b0;
    ram_addr    = index;
    unique case (state)
      IDLE: begin
        if (begin_transaction_in && select) begin
          index_n     = address_data_in[ADDR_BITS-1:0];
          remaining_n = BURST_W'(burst_size_in) + BURST_W'(1);
          count_n     = '0;
          state_n     = read_n_write_in ? RD_WAIT : WRITE;
        end
      end
      RD_WAIT: begin
        state_n = end_transaction_in ? IDLE : READ;
      end
      READ: begin
        // RAM fetches one word ahead of the word on the bus
        ram_addr    = index + 1'b1;
        index_n     = index + 1'b1;
        remaining_n = remaining - 1'b1;
        if (end_transaction_in) begin
          state_n = IDLE;
        end else if (last) begin
          state_n = RD_END;
        end else if (at_top) begin
          state_n = RD_END;
          error_n = 1'b1;
        end
      end
      WRITE: begin
        if (accept) begin
          index_n     = index + 1'b1;
          remaining_n = remaining - 1'b1;
          if (BUSY_EVERY != 0) begin
            if (count == CNT_W'(BUSY_EVERY - 1)) begin
              count_n = '0;
              busy_n  = 1'b1;
            end else begin
              count_n = count + 1'b1;
            end
          end
          // top word written with more to come: fault the
          // burst now rather than wrap into index 0
          if (!last && at_top && !end_transaction_in)
            error_n = 1'b1;
          if (last || at_top || end_transaction_in)
            state_n = IDLE;
        end else if (end_transaction_in) begin
          state_n = IDLE;
        end
      end
      RD_END: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  sp_ram_be #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clock        (clock),
    .write_enable (accept),
    .byte_enables (byte_enables_in),
    .address      (ram_addr),
    .write_data   (address_data_in),
    .read_data    (ram_rdata)
  );

  assign data_valid_out      = state == READ;
  assign address_data_out    = data_valid_out ? ram_rdata : '0;
  assign end_transaction_out = state == RD_END;
  assign busy_out            = busy;
  assign error_out           = error;

endmodule
